// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: word-wide datamem access,
// byte/half extract on load, read-modify-write on SB/SH.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dm_memwrite,
    output logic        dm_memread,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign,
    output logic [31:0] bad_addr,
    input  logic        misalign_clr
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] merge_q;
    logic [31:0] addr_q;

    logic [31:0] word_addr;
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [31:0] rsh_b;
    logic [31:0] rsh_h;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] merged;
    logic        is_ld;
    logic        is_half;
    logic        is_word;
    logic        is_rmw;
    logic        bad;
    logic        go;

    assign word_addr = {req_addr[31:2], 2'b00};

    // Bit offset of the addressed byte/half within the word
    assign bsh = BIG_ENDIAN ? {~req_addr[1:0], 3'b000}
                            : { req_addr[1:0], 3'b000};
    assign hsh = BIG_ENDIAN ? {~req_addr[1], 4'b0000}
                            : { req_addr[1], 4'b0000};

    assign rsh_b = dm_rdata >> bsh;
    assign rsh_h = dm_rdata >> hsh;
    assign rbyte = rsh_b[7:0];
    assign rhalf = rsh_h[15:0];

    assign is_ld   = (req_op <= OP_LW);
    assign is_half = (req_op == OP_LH) || (req_op == OP_LHU)
                  || (req_op == OP_SH);
    assign is_word = (req_op == OP_LW) || (req_op == OP_SW);
    assign is_rmw  = (req_op == OP_SB) || (req_op == OP_SH);

    assign bad = req_valid && (state == IDLE)
              && ((is_half && req_addr[0])
               || (is_word && (req_addr[1:0] != 2'b00)));
    assign go  = req_valid && (state == IDLE) && !bad;

    always_comb begin
        merged = dm_rdata;
        if (req_op == OP_SH)
            merged = (dm_rdata & ~(32'h0000_FFFF << hsh))
                   | ({16'h0000, req_wdata[15:0]} << hsh);
        else
            merged = (dm_rdata & ~(32'h0000_00FF << bsh))
                   | ({24'h000000, req_wdata[7:0]} << bsh);
    end

    // Outputs are gated by rst_n so a reset mid-RMW aborts the write at once
    always_comb begin
        dm_memwrite = 1'b0;
        dm_memread  = 1'b0;
        dm_addr     = 32'h0;
        dm_wdata    = 32'h0;
        load_data   = 32'h0;
        stall       = 1'b0;
        if (rst_n) begin
            if (state == RMW_WR) begin
                dm_memwrite = 1'b1;
                dm_addr     = addr_q;
                dm_wdata    = merge_q;
            end else if (go) begin
                dm_addr = word_addr;
                unique case (1'b1)
                    is_ld: begin
                        dm_memread = 1'b1;
                        case (req_op)
                            OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
                            OP_LBU:  load_data = {24'h0, rbyte};
                            OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
                            OP_LHU:  load_data = {16'h0, rhalf};
                            default: load_data = dm_rdata;
                        endcase
                    end
                    is_rmw: begin
                        dm_memread = 1'b1;
                        stall      = 1'b1;
                    end
                    default: begin
                        dm_memwrite = 1'b1;
                        dm_wdata    = req_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            merge_q  <= 32'h0;
            addr_q   <= 32'h0;
            misalign <= 1'b0;
            bad_addr <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go && is_rmw) begin
                        merge_q <= merged;
                        addr_q  <= word_addr;
                        state   <= RMW_WR;
                    end
                end
                RMW_WR: state <= IDLE;
            endcase
            if (misalign_clr) begin
                misalign <= 1'b0;
            end else if (bad) begin
                misalign <= 1'b1;
                if (!misalign)
                    bad_addr <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array datamem stub, byte-array
// reference memory, scoreboard of expected load results.
module tb_mem_access_unit;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LBU = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LHU = 3'd3;
    localparam logic [2:0] LW  = 3'd4;
    localparam logic [2:0] SB  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SW  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dm_memwrite;
    logic        dm_memread;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic [31:0] bad_addr;
    logic        misalign_clr;

    logic [31:0] dmem [0:255];
    logic [7:0]  rb   [0:1023];
    logic [31:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.BIG_ENDIAN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dm_memwrite  (dm_memwrite),
        .dm_memread   (dm_memread),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .load_data    (load_data),
        .stall        (stall),
        .misalign     (misalign),
        .bad_addr     (bad_addr),
        .misalign_clr (misalign_clr)
    );

    assign dm_rdata = dmem[dm_addr[9:2]];

    always @(posedge clk)
        if (dm_memwrite)
            dmem[dm_addr[9:2]] <= dm_wdata;

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        int b;
        b = int'({a[9:2], 2'b00});
        dmem[a[9:2]] = v;
        rb[b]   = v[31:24];
        rb[b+1] = v[23:16];
        rb[b+2] = v[15:8];
        rb[b+3] = v[7:0];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op,
                                             input logic [31:0] a);
        int b;
        logic [15:0] h;
        b = int'(a[9:0]);
        h = {rb[b], rb[(b+1) % 1024]};
        case (op)
            LB:      return {{24{rb[b][7]}}, rb[b]};
            LBU:     return {24'h0, rb[b]};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            default: return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] w);
        int b;
        b = int'(a[9:0]);
        case (op)
            SB: rb[b] = w[7:0];
            SH: begin
                rb[b]   = w[15:8];
                rb[b+1] = w[7:0];
            end
            default: begin
                rb[b]   = w[31:24];
                rb[b+1] = w[23:16];
                rb[b+2] = w[15:8];
                rb[b+3] = w[7:0];
            end
        endcase
    endtask

    // Drives one request from posedge+1, holding it through any stall
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] w, output logic [31:0] ld,
                         output int stalls, output int cycles);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = w;
        cycles    = 1;
        stalls    = 0;
        #4;
        ld = load_data;
        while (stall && cycles < 8) begin
            stalls++;
            @(posedge clk);
            #1;
            cycles++;
            #4;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        misalign_clr = 1'b0;
        req_valid    = 1'b1;
        req_op       = SW;
        req_addr     = 32'h100;
        req_wdata    = 32'hFFFF_FFFF;
        #7;
        n_cmp++;
        if ({dm_memwrite, dm_memread, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000",
                     {dm_memwrite, dm_memread, stall});
        end
        n_cmp++;
        if (dm_addr !== 32'h0 || dm_wdata !== 32'h0 || load_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want 0",
                     dm_addr, dm_wdata, load_data);
        end
        n_cmp++;
        if (misalign !== 1'b0 || bad_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_misalign: got %b %h want 0 0",
                     misalign, bad_addr);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        logic [2:0]  ops [6] = '{LB, LH, LB, LBU, LH, LHU};
        logic [31:0] ads [6] = '{32'h101, 32'h102, 32'h104,
                                 32'h104, 32'h104, 32'h106};
        logic [31:0] exs [6] = '{32'h0000_0022, 32'h0000_3344,
                                 32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_80FF, 32'h0000_7F01};
        logic [31:0] ld, e;
        int s, c;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exs[i]);
            do_op(ops[i], ads[i], 32'h0, ld, s, c);
            e = exp_q.pop_front();
            n_cmp++;
            if (ld !== e || s != 0) begin
                n_fail++;
                $display("FAIL load_%0d: got %h stalls %0d want %h stalls 0",
                         i, ld, s, e);
            end
        end
    endtask

    task automatic test_store_rmw();
        logic [31:0] ld, e;
        int s, c;
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h102;
        req_wdata = 32'hDEAD_BEAB;
        #4;
        n_cmp++;
        if ({stall, dm_memread, dm_memwrite} !== 3'b110) begin
            n_fail++;
            $display("FAIL sb_cycle1: got %b want 110",
                     {stall, dm_memread, dm_memwrite});
        end
        @(posedge clk);
        #5;
        n_cmp++;
        if ({stall, dm_memwrite} !== 2'b01 || dm_addr !== 32'h100
            || dm_wdata !== 32'h1122_AB44) begin
            n_fail++;
            $display("FAIL sb_cycle2: got %b %h %h want 01 100 1122ab44",
                     {stall, dm_memwrite}, dm_addr, dm_wdata);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ref_store(SB, 32'h102, 32'hDEAD_BEAB);
        exp_q.push_back(32'h1122_AB44);
        do_op(LW, 32'h100, 32'h0, ld, s, c);
        e = exp_q.pop_front();
        n_cmp++;
        if (ld !== e) begin
            n_fail++;
            $display("FAIL lw_after_sb: got %h want %h", ld, e);
        end
    endtask

    task automatic test_misalign();
        req_valid = 1'b1;
        req_op    = SH;
        req_addr  = 32'h101;
        req_wdata = 32'h1234;
        #4;
        n_cmp++;
        if ({dm_memread, dm_memwrite, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL sh_misaligned_access: got %b want 000",
                     {dm_memread, dm_memwrite, stall});
        end
        @(posedge clk);
        #1;
        req_op   = LW;
        req_addr = 32'h103;
        n_cmp++;
        if (misalign !== 1'b1 || bad_addr !== 32'h101) begin
            n_fail++;
            $display("FAIL misalign_set: got %b %h want 1 101",
                     misalign, bad_addr);
        end
        #4;
        n_cmp++;
        if (dm_memread !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misaligned_read: got %b want 0", dm_memread);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (misalign !== 1'b1 || bad_addr !== 32'h101) begin
            n_fail++;
            $display("FAIL bad_addr_sticky: got %b %h want 1 101",
                     misalign, bad_addr);
        end
        req_op       = SW;
        req_addr     = 32'h102;
        misalign_clr = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins: got %b want 0", misalign);
        end
        misalign_clr = 1'b0;
        req_op       = LH;
        req_addr     = 32'h205;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++;
        if (misalign !== 1'b1 || bad_addr !== 32'h205) begin
            n_fail++;
            $display("FAIL recapture: got %b %h want 1 205",
                     misalign, bad_addr);
        end
        misalign_clr = 1'b1;
        @(posedge clk);
        #1;
        misalign_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld, e;
        int s1, c1, s2, c2, s, c;
        set_word(32'h100, 32'h1122_3344);
        do_op(SB, 32'h100, 32'h0000_00AB, ld, s1, c1);
        do_op(SH, 32'h102, 32'h0000_CDEF, ld, s2, c2);
        n_cmp++;
        if (c1 + c2 != 4 || s1 + s2 != 2) begin
            n_fail++;
            $display("FAIL b2b_timing: got %0d cycles %0d stalls want 4 2",
                     c1 + c2, s1 + s2);
        end
        ref_store(SB, 32'h100, 32'hAB);
        ref_store(SH, 32'h102, 32'hCDEF);
        exp_q.push_back(32'hAB22_CDEF);
        do_op(LW, 32'h100, 32'h0, ld, s, c);
        e = exp_q.pop_front();
        n_cmp++;
        if (ld !== e) begin
            n_fail++;
            $display("FAIL b2b_word: got %h want %h", ld, e);
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] ld, e;
        int s, c;
        set_word(32'h108, 32'h5566_7788);
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h109;
        req_wdata = 32'h99;
        @(posedge clk);
        #2;
        n_cmp++;
        if (dm_memwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_wr_entered: got %b want 1", dm_memwrite);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dm_memwrite !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: got %b %b want 0 0", dm_memwrite, stall);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #5;
        n_cmp++;
        if (stall !== 1'b0 || dm_memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_idle: got %b %b want 0 0",
                     stall, dm_memwrite);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(32'h5566_7788);
        do_op(LW, 32'h108, 32'h0, ld, s, c);
        e = exp_q.pop_front();
        n_cmp++;
        if (ld !== e) begin
            n_fail++;
            $display("FAIL rst_mem_unchanged: got %h want %h", ld, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] ld, e, a, w;
        logic [2:0] op;
        int s, c;
        for (int i = 0; i < 64; i++)
            set_word(32'h200 + 32'(i * 4), $urandom);
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'h200 + 32'($urandom_range(0, 255));
            w  = $urandom;
            if (op == LW || op == SW)
                a[1:0] = 2'b00;
            else if (op == LH || op == LHU || op == SH)
                a[0] = 1'b0;
            if (op <= LW) begin
                exp_q.push_back(ref_load(op, a));
                do_op(op, a, w, ld, s, c);
                e = exp_q.pop_front();
                n_cmp++;
                if (ld !== e || s != 0) begin
                    n_fail++;
                    $display("FAIL rnd_load op%0d @%h: got %h want %h",
                             op, a, ld, e);
                end
            end else begin
                ref_store(op, a, w);
                do_op(op, a, w, ld, s, c);
                n_cmp++;
                if (c != ((op == SW) ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL rnd_store_cycles op%0d: got %0d", op, c);
                end
                exp_q.push_back(ref_load(LW, {a[31:2], 2'b00}));
                do_op(LW, {a[31:2], 2'b00}, 32'h0, ld, s, c);
                e = exp_q.pop_front();
                n_cmp++;
                if (ld !== e) begin
                    n_fail++;
                    $display("FAIL rnd_store op%0d @%h: got %h want %h",
                             op, a, ld, e);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            dmem[i] = 32'h0;
        for (int i = 0; i < 1024; i++)
            rb[i] = 8'h0;
        set_word(32'h100, 32'h1122_3344);
        set_word(32'h104, 32'h80FF_7F01);
        test_reset();
        test_loads();
        test_store_rmw();
        test_misalign();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
